// File: rtl/alu_share_sched_pkg.sv
// Shared types and constants for the ALU-sharing scheduler.
package alu_share_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned OP_W    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_share_sched_if.sv
// Request/response/ALU bundle between the requesters, the scheduler and the external ALU.
interface alu_share_sched_if #(
  parameter int WIDTH = 6
);
  import alu_share_pkg::*;

  logic [NUM_REQ-1:0]         req_valid_in;
  logic [NUM_REQ-1:0]         req_ready_out;
  logic [NUM_REQ*WIDTH-1:0]   req_a_in;
  logic [NUM_REQ*WIDTH-1:0]   req_b_in;
  logic [NUM_REQ*OP_W-1:0]    req_op_in;
  logic [NUM_REQ-1:0]         resp_valid_out;
  logic [NUM_REQ-1:0]         resp_ready_in;
  logic [2*WIDTH-1:0]         resp_c_out;
  logic                       resp_overflow_out;
  logic [WIDTH-1:0]           alu_a_out;
  logic [WIDTH-1:0]           alu_b_out;
  logic [OP_W-1:0]            alu_op_out;
  logic [2*WIDTH-1:0]         alu_c_in;
  logic                       alu_overflow_in;
  logic                       busy_out;

  modport master (
    output req_valid_in, req_a_in, req_b_in, req_op_in, resp_ready_in,
           alu_c_in, alu_overflow_in,
    input  req_ready_out, resp_valid_out, resp_c_out, resp_overflow_out,
           alu_a_out, alu_b_out, alu_op_out, busy_out
  );

  modport slave (
    input  req_valid_in, req_a_in, req_b_in, req_op_in, resp_ready_in,
           alu_c_in, alu_overflow_in,
    output req_ready_out, resp_valid_out, resp_c_out, resp_overflow_out,
           alu_a_out, alu_b_out, alu_op_out, busy_out
  );

endinterface

// File: rtl/alu_share_sched_pick.sv
// Two-way grant: the pointer's requester wins when valid, otherwise the other one.
module alu_share_pick
  import alu_share_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic               ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_idx
);

  logic other_s;
  assign other_s = ~ptr;

  // Priority select between the pointed-to and the alternate requester.
  always_comb begin
    grant     = 2'b00;
    grant_idx = 1'b0;
    if (valid[ptr]) begin
      grant     = idx_to_onehot(ptr);
      grant_idx = ptr;
    end else if (valid[other_s]) begin
      grant     = idx_to_onehot(other_s);
      grant_idx = other_s;
    end else begin
      grant     = 2'b00;
      grant_idx = 1'b0;
    end
  end

endmodule

// File: rtl/alu_share_sched.sv
// Shares one external ALU between two requesters: arbitrate, issue for ALU_LAT cycles, return result.
// Define ALU_SHARE_RR_EN for round-robin ties; otherwise requester 0 has fixed priority.
module alu_share_sched
  import alu_share_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int ALU_LAT = 1
) (
  input logic              clk,
  input logic              rst,
  alu_share_sched_if.slave bus
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_e             state_r;
  logic               owner_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [OP_W-1:0]    op_r;
  logic [2*WIDTH-1:0] c_r;
  logic               ovf_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [NUM_REQ-1:0] resp_valid_r;
  logic               busy_r;
  logic               ptr_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               grant_idx_s;

`ifdef ALU_SHARE_RR_EN
  logic ptr_r;
  assign ptr_s = ptr_r;
`else
  assign ptr_s = 1'b0;
`endif

  alu_share_pick u_pick (
    .valid     (bus.req_valid_in),
    .ptr       (ptr_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  // The grant only ever contains valid requesters, so it doubles as ready.
  assign bus.req_ready_out     = (state_r == IDLE) ? grant_s : {NUM_REQ{1'b0}};
  assign bus.resp_valid_out    = resp_valid_r;
  assign bus.resp_c_out        = c_r;
  assign bus.resp_overflow_out = ovf_r;
  assign bus.alu_a_out         = a_r;
  assign bus.alu_b_out         = b_r;
  assign bus.alu_op_out        = op_r;
  assign bus.busy_out          = busy_r;

  // Accept, ALU countdown and response hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      owner_r      <= 1'b0;
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      op_r         <= {OP_W{1'b0}};
      c_r          <= {(2*WIDTH){1'b0}};
      ovf_r        <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
      resp_valid_r <= {NUM_REQ{1'b0}};
      busy_r       <= 1'b0;
`ifdef ALU_SHARE_RR_EN
      ptr_r        <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (|grant_s) begin
            a_r     <= grant_idx_s ? bus.req_a_in[WIDTH +: WIDTH] : bus.req_a_in[0 +: WIDTH];
            b_r     <= grant_idx_s ? bus.req_b_in[WIDTH +: WIDTH] : bus.req_b_in[0 +: WIDTH];
            op_r    <= grant_idx_s ? bus.req_op_in[OP_W +: OP_W] : bus.req_op_in[0 +: OP_W];
            owner_r <= grant_idx_s;
            cnt_r   <= CNT_W'(ALU_LAT - 1);
            busy_r  <= 1'b1;
            state_r <= ISSUE;
`ifdef ALU_SHARE_RR_EN
            ptr_r   <= ~grant_idx_s;
`endif
          end
        end
        ISSUE: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            c_r          <= bus.alu_c_in;
            ovf_r        <= bus.alu_overflow_in;
            resp_valid_r <= idx_to_onehot(owner_r);
            state_r      <= RESP;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.resp_ready_in[owner_r]) begin
            resp_valid_r <= {NUM_REQ{1'b0}};
            busy_r       <= 1'b0;
            state_r      <= IDLE;
          end
        end
        default: begin
          resp_valid_r <= {NUM_REQ{1'b0}};
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_sched.sv
// Scoreboard bench for alu_share_sched with a latency-3 behavioural ALU.
`timescale 1ns/1ps
module tb_alu_share_sched;

  localparam int WIDTH = 6;
  localparam int LAT   = 3;
  localparam int RW    = 2*WIDTH;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
  } req_t;

  typedef struct {
    logic          owner;
    logic [RW-1:0] c;
    logic          ovf;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_share_sched_if #(.WIDTH(WIDTH)) bus ();

  alu_share_sched #(.WIDTH(WIDTH), .ALU_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accepts = 0;
  int   last_acc = 0;
  bit   tight = 1'b0;
  int   tight_n = 0;
  bit   in_resp = 1'b0;
  bit   done_prev = 1'b0;
  logic ptr_m = 1'b0;
  exp_t sb_q[$];
  exp_t cur;
  int   grant_log[$];
  req_t q0[$];
  req_t q1[$];
  logic [1:0]    h_valid;
  logic [RW-1:0] h_c;
  logic          h_ovf;

  // Reference ALU: add/sub with carry/borrow as overflow, multiply, xor.
  function automatic logic [RW:0] alu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic [1:0] op);
    int unsigned ai = a;
    int unsigned bi = b;
    int unsigned r;
    logic o;
    case (op)
      2'd0:    begin r = ai + bi; o = (r > ((1 << WIDTH) - 1)); end
      2'd1:    begin r = (ai - bi) & ((1 << RW) - 1); o = (ai < bi); end
      2'd2:    begin r = ai * bi; o = 1'b0; end
      default: begin r = ai ^ bi; o = 1'b0; end
    endcase
    return {o, r[RW-1:0]};
  endfunction

  // Bench ALU: result reflects the inputs seen LAT-1 cycles earlier.
  logic [2*WIDTH+1:0] alu_pipe [LAT-1];
  logic [RW:0]        alu_res;
  always @(posedge clk) begin
    alu_pipe[0] <= {bus.alu_a_out, bus.alu_b_out, bus.alu_op_out};
    for (int k = 1; k < LAT-1; k++) alu_pipe[k] <= alu_pipe[k-1];
  end
  assign alu_res = alu_ref(alu_pipe[LAT-2][2*WIDTH+1 -: WIDTH], alu_pipe[LAT-2][WIDTH+1 -: WIDTH],
                           alu_pipe[LAT-2][1:0]);
  assign bus.alu_c_in        = alu_res[RW-1:0];
  assign bus.alu_overflow_in = alu_res[RW];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A reset abandons everything in flight.
  always @(posedge rst) begin
    sb_q.delete();
    in_resp   = 1'b0;
    done_prev = 1'b0;
    ptr_m     = 1'b0;
    accepts   = 0;
    tight_n   = 0;
  end

  // Requester driver: present queue heads, advance on handshake.
  initial begin
    logic [1:0] acc;
    bus.req_valid_in = 2'b00;
    bus.req_a_in     = '0;
    bus.req_b_in     = '0;
    bus.req_op_in    = '0;
    forever begin
      @(negedge clk);
      acc = rst ? 2'b00 : (bus.req_ready_out & bus.req_valid_in);
      @(posedge clk); #1;
      if (acc[0]) void'(q0.pop_front());
      if (acc[1]) void'(q1.pop_front());
      if (q0.size() > 0) begin
        bus.req_a_in[0 +: WIDTH] = q0[0].a; bus.req_b_in[0 +: WIDTH] = q0[0].b;
        bus.req_op_in[1:0] = q0[0].op; bus.req_valid_in[0] = 1'b1;
      end else bus.req_valid_in[0] = 1'b0;
      if (q1.size() > 0) begin
        bus.req_a_in[WIDTH +: WIDTH] = q1[0].a; bus.req_b_in[WIDTH +: WIDTH] = q1[0].b;
        bus.req_op_in[3:2] = q1[0].op; bus.req_valid_in[1] = 1'b1;
      end else bus.req_valid_in[1] = 1'b0;
    end
  end

  // Monitor: arbitration model, scoreboard push on accept, pop and compare on response.
  initial begin
    logic [1:0] hs;
    logic g;
    logic [RW:0] r;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_resp_valid", bus.resp_valid_out, 0);
        chk("rst_busy", bus.busy_out, 0);
        chk("rst_resp_c", bus.resp_c_out, 0);
        chk("rst_resp_ovf", bus.resp_overflow_out, 0);
        chk("rst_alu_drive", {bus.alu_a_out, bus.alu_b_out, bus.alu_op_out}, 0);
        if (bus.req_valid_in == 2'b00) chk("rst_ready", bus.req_ready_out, 0);
      end else begin
        if (done_prev) begin
          chk("idle_after_resp_busy", bus.busy_out, 0);
          chk("idle_after_resp_valid", bus.resp_valid_out, 0);
          done_prev = 1'b0;
        end
        if (bus.req_ready_out != 2'b00) begin
          chk("ready_onehot", $countones(bus.req_ready_out), 1);
          chk("ready_only_idle", bus.busy_out, 0);
          chk("ready_subset_valid", bus.req_ready_out & ~bus.req_valid_in, 0);
        end
        hs = bus.req_ready_out & bus.req_valid_in;
        if (hs != 2'b00) begin
          g = hs[1];
          if (bus.req_valid_in == 2'b11) chk("tie_winner", g, ptr_m);
          else chk("single_winner", g, bus.req_valid_in[1]);
`ifdef ALU_SHARE_RR_EN
          ptr_m = ~g;
`endif
          if (accepts > 0) chk("spacing_min", (cyc - last_acc) >= LAT + 2, 1);
          if (tight && tight_n > 0) chk("spacing_exact", cyc - last_acc, LAT + 2);
          if (tight) tight_n++;
          last_acc = cyc;
          accepts++;
          grant_log.push_back(g);
          r = g ? alu_ref(bus.req_a_in[WIDTH +: WIDTH], bus.req_b_in[WIDTH +: WIDTH], bus.req_op_in[3:2])
                : alu_ref(bus.req_a_in[0 +: WIDTH], bus.req_b_in[0 +: WIDTH], bus.req_op_in[1:0]);
          e.owner = g; e.c = r[RW-1:0]; e.ovf = r[RW]; e.cyc = cyc;
          sb_q.push_back(e);
        end
        if (bus.resp_valid_out != 2'b00) begin
          if (!in_resp) begin
            if (sb_q.size() == 0) chk("resp_unexpected", bus.resp_valid_out, 0);
            else begin
              cur = sb_q.pop_front();
              chk("resp_owner", bus.resp_valid_out, cur.owner ? 2'b10 : 2'b01);
              chk("resp_c", bus.resp_c_out, cur.c);
              chk("resp_ovf", bus.resp_overflow_out, cur.ovf);
              chk("resp_latency", cyc - cur.cyc, LAT + 1);
              in_resp = 1'b1;
            end
          end else begin
            chk("hold_valid", bus.resp_valid_out, h_valid);
            chk("hold_c", bus.resp_c_out, h_c);
            chk("hold_ovf", bus.resp_overflow_out, h_ovf);
          end
          h_valid = bus.resp_valid_out; h_c = bus.resp_c_out; h_ovf = bus.resp_overflow_out;
          if (in_resp && (bus.resp_valid_out & bus.resp_ready_in) != 2'b00) begin
            in_resp   = 1'b0;
            done_prev = 1'b1;
          end
        end else if (in_resp) begin
          chk("resp_dropped", bus.resp_valid_out, h_valid);
          in_resp = 1'b0;
        end
      end
    end
  end

  task automatic push_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [1:0] op);
    req_t r;
    r.a = a; r.b = b; r.op = op;
    if (i == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || sb_q.size() > 0 || in_resp || bus.busy_out) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) chk({name, "_timeout"}, 1, 0);
    @(negedge clk);
  endtask

  task automatic wait_resp(input string name);
    int k = 0;
    while (bus.resp_valid_out == 2'b00 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk({name, "_timeout"}, 1, 0);
  endtask

  initial begin
    int s;
    bus.resp_ready_in = 2'b11;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;

    // Directed 5 + 3 from requester 0.
    @(negedge clk);
    push_req(0, 6'd5, 6'd3, 2'd0);
    @(negedge clk);
    chk("first_ready", bus.req_ready_out, 2'b01);
    repeat (LAT + 1) @(negedge clk);
    chk("first_resp_valid", bus.resp_valid_out, 2'b01);
    chk("first_resp_c", bus.resp_c_out, 8);
    wait_drain("first");

    // Tie: both requesters hold valid back to back.
    s = grant_log.size();
    tight = 1'b1; tight_n = 0;
    for (int n = 0; n < 4; n++) begin
      push_req(0, 6'($urandom), 6'($urandom), 2'($urandom));
      push_req(1, 6'($urandom), 6'($urandom), 2'($urandom));
    end
    wait_drain("tie");
    tight = 1'b0;
    chk("tie_count", grant_log.size() - s, 8);
`ifdef ALU_SHARE_RR_EN
    for (int k = 1; k < 8; k++) chk("tie_alternate", grant_log[s+k] != grant_log[s+k-1], 1);
`else
    for (int k = 0; k < 4; k++) chk("tie_fixed_prio", grant_log[s+k], 0);
`endif

    // Backpressure with a competing request waiting.
    bus.resp_ready_in = 2'b00;
    push_req(1, 6'd40, 6'd50, 2'd1);
    wait_resp("bp");
    push_req(0, 6'd63, 6'd63, 2'd0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_no_grant", bus.req_ready_out, 0);
      chk("bp_valid", bus.resp_valid_out, 2'b10);
    end
    @(posedge clk); #1 bus.resp_ready_in = 2'b11;
    wait_drain("bp");

    // Ready from the wrong requester must not consume the response.
    bus.resp_ready_in = 2'b01;
    push_req(1, 6'd7, 6'd9, 2'd1);
    wait_resp("wrong_owner");
    repeat (4) @(negedge clk);
    chk("wrong_owner_hold", bus.resp_valid_out, 2'b10);
    @(posedge clk); #1 bus.resp_ready_in = 2'b10;
    wait_drain("wrong_owner");
    bus.resp_ready_in = 2'b11;

    // Reset during ISSUE while requester 1 waits.
    push_req(0, 6'd11, 6'd22, 2'd0);
    s = 0;
    while (!bus.busy_out && s < 50) begin @(negedge clk); s++; end
    chk("rst_issue_reached", bus.busy_out, 1);
    push_req(1, 6'd33, 6'd1, 2'd1);
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus.busy_out, 0);
    chk("abort_resp_valid", bus.resp_valid_out, 0);
    chk("abort_reaccept", bus.req_ready_out, 2'b10);
    wait_drain("abort");

    // Randomized traffic with random response backpressure.
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      bus.resp_ready_in = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        s = $urandom_range(0, 1);
        if ((s == 0 && q0.size() < 2) || (s == 1 && q1.size() < 2))
          push_req(s, 6'($urandom), 6'($urandom), 2'($urandom));
      end
    end
    @(posedge clk); #1 bus.resp_ready_in = 2'b11;
    wait_drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_share_sched.md
# alu_share_sched

Scheduler sharing one 6-bit ALU datapath between two requesters (e.g. the switch-panel front end and a scripted self-test sequencer). It arbitrates requests, latches the winner's operands and opcode, drives the ALU for a configurable number of cycles, and captures the 12-bit result and overflow flag. It then returns them to the winning requester over a valid/ready response handshake. The ALU sits outside this block and connects through the `alu_*` ports.

## Interface
Parameters:
- `WIDTH`, 6: operand width. Result width is 2*WIDTH.
- `ALU_LAT`, 1: cycles the ALU inputs are held before capture. Must be ≥1; 1 = purely combinational ALU.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid_in` in 2: request valid, bit i = requester i.
- `req_ready_out` out 2: request accepted this cycle, bit i.
- `req_a_in` in 2*WIDTH: operand A; requester i in `[i*WIDTH +: WIDTH]`.
- `req_b_in` in 2*WIDTH: operand B, same packing.
- `req_op_in` in 4: opcode; requester i in `[2*i +: 2]`.
- `resp_valid_out` out 2: response valid, bit = owning requester.
- `resp_ready_in` in 2: response consumed, bit i.
- `resp_c_out` out 2*WIDTH: captured ALU result.
- `resp_overflow_out` out 1: captured ALU overflow.
- `alu_a_out` out WIDTH, `alu_b_out` out WIDTH, `alu_op_out` out 2: ALU drive.
- `alu_c_in` in 2*WIDTH, `alu_overflow_in` in 1: ALU result.
- `busy_out` out 1: high in any state but IDLE.

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE
  - Grant g is computed combinationally from `req_valid_in` and the priority pointer.
  - `req_ready_out[g]` = 1 only when `req_valid_in[g]` = 1.
  - On the handshake: latch g's A/B/op, record owner = g, load the cycle counter with ALU_LAT-1, go to ISSUE.
- ISSUE
  - `alu_*_out` are driven from the latched registers.
  - The counter decrements each cycle.
  - On the cycle the counter is 0: capture `alu_c_in` and `alu_overflow_in` into the response registers, go to RESP.
- RESP
  - `resp_valid_out[owner]` = 1, held until `resp_ready_in[owner]` = 1; then go to IDLE.
  - `resp_ready_in` of the non-owner is ignored.
- Outside ISSUE, `alu_*_out` hold the last latched values.
- Response data is stable for as long as valid is asserted.
- Both requesters valid in IDLE: the pointer's requester wins.
  - On each accept the pointer moves to the other requester (see Configuration).
- Only one of the two `req_ready_out` bits is ever high, and never outside IDLE.
- Requests arriving outside IDLE wait. Requesters must hold valid and data stable until ready.
- Reset values:
  - state IDLE, pointer 0, owner 0.
  - all latched operand, opcode and result registers 0.
  - `req_ready_out` = 0, `resp_valid_out` = 0, `busy_out` = 0.
- Reset mid-operation abandons the transaction; no response is ever produced for it.

## Timing
- Accept on edge T.
- ISSUE spans cycles T+1 … T+ALU_LAT; capture on the edge ending cycle T+ALU_LAT.
- `resp_valid_out` is high from cycle T+ALU_LAT+1.
- With `resp_ready_in` already high, the response completes in that cycle and IDLE is reached the next cycle.
- Minimum accept-to-accept spacing: ALU_LAT+2 cycles.
- `req_ready_out` is combinational from `req_valid_in` and state. There are no other combinational input-to-output paths.

## Configuration
- `ALU_SHARE_RR_EN` defined: round-robin. On every accept the pointer becomes 1-g.
- Undefined: fixed priority, requester 0 always wins ties. The pointer register is removed and tied to 0.

## Structure
- Shared package `alu_share_pkg`:
  - state enumeration: IDLE, ISSUE, RESP.
  - requester count constant: 2.
  - opcode width constant: 2.
- One sub-module, `alu_share_pick`: combinational 2-way grant from valid bits and pointer. It outputs the one-hot grant and the grant index.

## Test plan
The bench ALU model: op 0 returns A+B, op 1 returns A−B; overflow per the model.
- Reset: after `rst` pulse, all outputs 0, `busy_out` = 0. Then requester 0 sends A=5, B=3, op 0 → ready in cycle 0, `resp_c_out` = 8 with `resp_valid_out` = 2'b01 at cycle ALU_LAT+1.
- Tie with `ALU_SHARE_RR_EN`: both valid continuously → grants alternate 0,1,0,1. Without the macro → requester 0 is granted every time.
- Backpressure: hold `resp_ready_in` = 0 for 5 cycles → valid and `resp_c_out` stay stable, no new grant. Release → IDLE next cycle.
- ALU_LAT = 3: bench ALU updates its output only after 3 cycles → capture equals the 3rd-cycle value. Spacing between accepts = 5 cycles.
- Wrong-owner ready: owner 1, assert only `resp_ready_in[0]` → response not consumed.
- Reset asserted during ISSUE: next cycle state is IDLE with no `resp_valid_out`. The pending request is re-accepted once `rst` is released.
